// File: rtl/vid_pkg.sv
// Shared video types and pixel-format helpers for the frame-buffer read path.
// Frame geometry, the grayscale mode code and the luma weights live here.
package vid_pkg;

  localparam int FB_WIDTH  = 320;
  localparam int FB_HEIGHT = 240;

  localparam logic [2:0] MODE_GRAY = 3'd2;

  localparam logic [7:0] GRAY_KR = 8'd77;
  localparam logic [7:0] GRAY_KG = 8'd150;
  localparam logic [7:0] GRAY_KB = 8'd29;

  typedef struct packed {
    logic [29:0] data;
    logic        sop;
    logic        eop;
  } pix_beat_t;

  // Each 4-bit channel is replicated into the upper 8 bits of a 10-bit field.
  function automatic logic [29:0] rgb444_to_rgb30(input logic [11:0] rgb);
    return {rgb[11:8], rgb[11:8], 2'b00,
            rgb[7:4],  rgb[7:4],  2'b00,
            rgb[3:0],  rgb[3:0],  2'b00};
  endfunction

  // Weighted luma; the 18-bit sum peaks at 1020*256, so bits [17:8] hold the result.
  function automatic logic [29:0] rgb30_to_gray30(input logic [29:0] rgb);
    logic [17:0] sum;
    sum = 18'(rgb[29:20]) * 18'(GRAY_KR)
        + 18'(rgb[19:10]) * 18'(GRAY_KG)
        + 18'(rgb[9:0])   * 18'(GRAY_KB);
    return {3{sum[17:8]}};
  endfunction

endpackage

// File: rtl/fb_pixel_fifo.sv
// Two-entry beat FIFO between the frame-buffer read port and the video sink.
// The flush input clears the FIFO synchronously, just as reset does.
module fb_pixel_fifo
  import vid_pkg::*;
(
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push,
  input  logic [$bits(pix_beat_t)-1:0]  push_beat,
  input  logic                          pop,
  output logic [$bits(pix_beat_t)-1:0]  head,
  output logic [1:0]                    count
);

  pix_beat_t mem [2];
  logic      rd_ptr;
  logic      wr_ptr;
  logic      do_push;
  logic      do_pop;

  assign do_push = push && (count != 2'd2);
  assign do_pop  = pop && (count != 2'd0);

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= pix_beat_t'(push_beat);
        wr_ptr      <= !wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= !rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fb_stream_reader.sv
// Raster-order frame-buffer reader that turns RGB444 words into an Avalon-ST
// video packet, hiding the one-cycle RAM latency behind a two-entry FIFO.
module fb_stream_reader
  import vid_pkg::*;
#(
  parameter int WIDTH  = FB_WIDTH,
  parameter int HEIGHT = FB_HEIGHT,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [2:0]        menu_choice,
  output logic [ADDR_W-1:0] rd_address,
  input  logic [11:0]       rd_data,
  output logic [29:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sop,
  output logic              out_eop
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             at_first;
  logic             at_last_col;
  logic             at_last;

  logic             inflight;
  logic             inflight_sop;
  logic             inflight_eop;
  logic             inflight_gray;
  logic             frame_gray;
  logic             issue_gray;

  logic             issue;
  logic             pop_fire;
  logic [2:0]       occupancy_after;
  logic [1:0]       fifo_count;
  logic [$bits(pix_beat_t)-1:0] head_bits;
  pix_beat_t        head;
  pix_beat_t        push_beat;

  assign at_first    = (col == '0) && (row == '0);
  assign at_last_col = (col == COL_W'(WIDTH - 1));
  assign at_last     = at_last_col && (row == ROW_W'(HEIGHT - 1));

  // Credit counts the slot freed by this cycle's pop, which is what keeps one pixel per clock.
  assign pop_fire        = out_valid && out_ready;
  assign occupancy_after = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop_fire};
  assign issue           = !reset && !restart && (occupancy_after < 3'd2);

  assign issue_gray = at_first ? (menu_choice == MODE_GRAY) : frame_gray;

  always_ff @(posedge clk) begin
    if (reset || restart) begin
      col           <= '0;
      row           <= '0;
      rd_address    <= '0;
      inflight      <= 1'b0;
      inflight_sop  <= 1'b0;
      inflight_eop  <= 1'b0;
      inflight_gray <= 1'b0;
      frame_gray    <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_sop  <= at_first;
        inflight_eop  <= at_last;
        inflight_gray <= issue_gray;
        frame_gray    <= issue_gray;
        if (at_last_col) begin
          col <= '0;
          row <= at_last ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
        rd_address <= at_last ? '0 : rd_address + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    push_beat      = '0;
    push_beat.data = inflight_gray ? rgb30_to_gray30(rgb444_to_rgb30(rd_data))
                                   : rgb444_to_rgb30(rd_data);
    push_beat.sop  = inflight_sop;
    push_beat.eop  = inflight_eop;
  end

  fb_pixel_fifo u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (restart),
    .push      (inflight),
    .push_beat (push_beat),
    .pop       (pop_fire),
    .head      (head_bits),
    .count     (fifo_count)
  );

  assign head      = pix_beat_t'(head_bits);
  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = head.data;
  assign out_sop   = head.sop;
  assign out_eop   = head.eop;

endmodule
